// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: AC lookup, CR response, CD line stream, state update.
// ACE_SNOOP_RSP_PREFETCH_EN: two reads in flight via a 2-entry CD FIFO.
module ace_snoop_responder #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineBytes = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 tag_req_o,
  input  logic                 tag_gnt_i,
  output logic [AddrWidth-1:0] tag_addr_o,
  input  logic                 tag_rvalid_i,
  input  logic                 tag_hit_i,
  input  logic                 tag_dirty_i,
  input  logic                 tag_unique_i,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic [$clog2(LineBytes*8/DataWidth)-1:0] data_beat_o,
  input  logic                 data_rvalid_i,
  input  logic [DataWidth-1:0] data_rdata_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic [1:0]           upd_op_o
);

  localparam int unsigned Beats = LineBytes * 8 / DataWidth;
  localparam int unsigned BW    = $clog2(Beats);
  localparam int unsigned OffW  = $clog2(LineBytes);
  localparam int unsigned ByteW = $clog2(DataWidth / 8);
  localparam int unsigned CW    = BW + 1;
  localparam logic [CW-1:0] BeatsC = CW'(Beats);
  localparam logic [CW-1:0] LastC  = CW'(Beats - 1);

  localparam logic [1:0] OpNone = 2'b00;
  localparam logic [1:0] OpShCl = 2'b01;
  localparam logic [1:0] OpInv  = 2'b10;

  localparam logic [3:0] SnpRdOnce  = 4'b0000;
  localparam logic [3:0] SnpRdShr   = 4'b0001;
  localparam logic [3:0] SnpRdCln   = 4'b0010;
  localparam logic [3:0] SnpRdNsd   = 4'b0011;
  localparam logic [3:0] SnpRdUniq  = 4'b0111;
  localparam logic [3:0] SnpClnShr  = 4'b1000;
  localparam logic [3:0] SnpClnInv  = 4'b1001;
  localparam logic [3:0] SnpMkInv   = 4'b1101;

  typedef enum logic [2:0] {
    Idle, Lookup, WaitTag, Resp, Data, Update
  } state_e;

  // Returns {op[1:0], WU, IS, PD, Err, DT}; everything is zero on a miss.
  function automatic logic [6:0] rsp_f(
    input logic [3:0] snp,
    input logic       h,
    input logic       d,
    input logic       u
  );
    logic       dt, is_s, pd, wu;
    logic [1:0] op;
    dt = 1'b0; is_s = 1'b0; pd = 1'b0; wu = 1'b0; op = OpNone;
    unique case (1'b1)
      (snp == SnpRdOnce): begin
        dt = 1'b1; is_s = 1'b1; wu = u;
      end
      (snp == SnpRdShr) || (snp == SnpRdCln) || (snp == SnpRdNsd): begin
        dt = 1'b1; is_s = 1'b1; pd = d; wu = u; op = OpShCl;
      end
      (snp == SnpRdUniq): begin
        dt = 1'b1; pd = d; wu = u; op = OpInv;
      end
      (snp == SnpClnInv): begin
        dt = d; pd = d; wu = u; op = OpInv;
      end
      (snp == SnpClnShr): begin
        dt = d; pd = d; is_s = 1'b1; wu = u;
        op = d ? OpShCl : OpNone;
      end
      (snp == SnpMkInv): begin
        wu = u; op = OpInv;
      end
      default: ;
    endcase
    if (!h) return 7'd0;
    return {op, wu, is_s, pd, 1'b0, dt};
  endfunction

  state_e                   state_q, state_d;
  logic [AddrWidth-OffW-1:0] line_q, line_d;
  logic [3:0]               snoop_q, snoop_d;
  logic [BW-1:0]            start_q, start_d;
  logic [4:0]               resp_q, resp_d;
  logic [1:0]               op_q, op_d;
  logic [CW-1:0]            req_cnt_q, req_cnt_d;
  logic [CW-1:0]            cd_cnt_q, cd_cnt_d;
  logic [1:0]               out_q, out_d;
  logic                     ac_ready_q, ac_ready_d;

  logic in_data, push, pop, issue, more;
  logic unused_addr;

  assign unused_addr = ^ac_addr_i[ByteW-1:0];

  assign in_data = (state_q == Data);
  assign push    = in_data && data_rvalid_i && (out_q != 2'd0);
  assign pop     = cd_valid_o && cd_ready_i;
  assign issue   = data_req_o && data_gnt_i;
  assign more    = (req_cnt_q != BeatsC);
  assign out_d   = out_q + {1'b0, issue} - {1'b0, push};

  assign ac_ready_o  = ac_ready_q;
  assign cr_resp_o   = resp_q;
  assign upd_op_o    = op_q;
  assign tag_addr_o  = {line_q, {OffW{1'b0}}};
  assign data_beat_o = start_q + req_cnt_q[BW-1:0];
  assign cd_last_o   = cd_valid_o && (cd_cnt_q == LastC);

`ifdef ACE_SNOOP_RSP_PREFETCH_EN
  logic [DataWidth-1:0] fifo_q [2];
  logic [DataWidth-1:0] fifo_d [2];
  logic                 wptr_q, wptr_d;
  logic                 rptr_q, rptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [2:0]           credit;

  // A read may issue as long as in-flight plus buffered beats stay within 2.
  assign credit = {1'b0, out_q} + {1'b0, cnt_q} - {2'b0, pop};
  assign data_req_o = in_data && more && (cnt_q != 2'd2)
                    && (credit < 3'd2);
  assign cd_valid_o = in_data && (cnt_q != 2'd0);
  assign cd_data_o  = fifo_q[rptr_q];

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = data_rdata_i;
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  logic [DataWidth-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;

  assign data_req_o = in_data && more && (out_q == 2'd0) && !hold_vld_q;
  assign cd_valid_o = in_data && hold_vld_q;
  assign cd_data_o  = hold_q;

  always_comb begin
    hold_d     = push ? data_rdata_i : hold_q;
    hold_vld_d = (hold_vld_q & ~pop) | push;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    snoop_d   = snoop_q;
    start_d   = start_q;
    resp_d    = resp_q;
    op_d      = op_q;
    req_cnt_d = req_cnt_q;
    cd_cnt_d  = cd_cnt_q;
    tag_req_o   = 1'b0;
    cr_valid_o  = 1'b0;
    upd_valid_o = 1'b0;
    unique case (state_q)
      Idle: begin
        if (ac_valid_i && ac_ready_q) begin
          line_d  = ac_addr_i[AddrWidth-1:OffW];
          snoop_d = ac_snoop_i;
          start_d = ac_addr_i[OffW-1:ByteW];
          state_d = Lookup;
        end
      end
      Lookup: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) state_d = WaitTag;
      end
      WaitTag: begin
        if (tag_rvalid_i) begin
          {op_d, resp_d} = rsp_f(snoop_q, tag_hit_i,
                                 tag_dirty_i, tag_unique_i);
          state_d = Resp;
        end
      end
      Resp: begin
        cr_valid_o = 1'b1;
        if (cr_ready_i) begin
          req_cnt_d = '0;
          cd_cnt_d  = '0;
          if (resp_q[0])           state_d = Data;
          else if (op_q != OpNone) state_d = Update;
          else                     state_d = Idle;
        end
      end
      Data: begin
        if (issue) req_cnt_d = req_cnt_q + CW'(1);
        if (pop) begin
          cd_cnt_d = cd_cnt_q + CW'(1);
          if (cd_last_o)
            state_d = (op_q == OpNone) ? Idle : Update;
        end
      end
      Update: begin
        upd_valid_o = 1'b1;
        if (upd_ready_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
    ac_ready_d = (state_d == Idle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      line_q     <= '0;
      snoop_q    <= 4'd0;
      start_q    <= '0;
      resp_q     <= 5'd0;
      op_q       <= OpNone;
      req_cnt_q  <= '0;
      cd_cnt_q   <= '0;
      out_q      <= 2'd0;
      ac_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      snoop_q    <= snoop_d;
      start_q    <= start_d;
      resp_q     <= resp_d;
      op_q       <= op_d;
      req_cnt_q  <= req_cnt_d;
      cd_cnt_q   <= cd_cnt_d;
      out_q      <= out_d;
      ac_ready_q <= ac_ready_d;
    end
  end

endmodule
